// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: transaction state encodings and default sizes.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;
  localparam int unsigned SPI_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SEND   = 3'd4,
    WRITE_RECV  = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } spi_state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK edge counter; o_last flags that the next increment completes a byte.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == LAST_CNT);

endmodule

// File: rtl/spi_transaction_ctrl.sv
// Chip-select framed SPI slave transaction sequencer driving datapath strobes.
module spi_transaction_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclkPosEdge,
  input  logic       sclkNegEdge,
  input  logic       chipSelect,
  input  logic       rwBit,
  output logic       srParallelLoad,
  output logic       addrLatchEnable,
  output logic       dmWriteEnable,
  output logic       misoBufferEnable,
  output logic       busy,
  output logic [2:0] stateOut
);

  spi_state_t r_state;
  logic       r_sr_load;
  logic       r_addr_le;
  logic       r_dm_we;
  logic       r_miso_en;
  logic       r_busy;

  logic w_pos_state;
  logic w_count_state;
  logic w_edge;
  logic w_abort;
  logic w_last;
  logic w_hit;
  logic w_cnt_clr;
  logic w_cnt_inc;

  always_comb begin
    w_pos_state   = (r_state == GET_ADDR) || (r_state == WRITE_RECV);
    w_count_state = w_pos_state || (r_state == READ_SEND);
    // Each counting state watches only its own SCLK edge.
    w_edge    = (w_pos_state && sclkPosEdge) ||
                ((r_state == READ_SEND) && sclkNegEdge);
    w_abort   = chipSelect && (r_state != IDLE);
    w_hit     = w_edge && w_last && !w_abort;
    w_cnt_inc = w_edge && !w_abort;
    w_cnt_clr = w_abort || w_hit || !w_count_state;
  end

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sr_load <= 1'b0;
      r_addr_le <= 1'b0;
      r_dm_we   <= 1'b0;
      r_miso_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sr_load <= 1'b0;
      r_addr_le <= 1'b0;
      r_dm_we   <= 1'b0;
      if (w_abort) begin
        // CS release also ends a completed transaction from DONE.
        r_state   <= IDLE;
        r_miso_en <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (!chipSelect) begin
              r_state <= GET_ADDR;
              r_busy  <= 1'b1;
            end
          end
          GET_ADDR: begin
            if (w_hit) begin
              r_state   <= GOT_ADDR;
              r_addr_le <= 1'b1;
            end
          end
          GOT_ADDR: begin
            if (rwBit) begin
              r_state   <= READ_LOAD;
              r_sr_load <= 1'b1;
            end else begin
              r_state <= WRITE_RECV;
            end
          end
          READ_LOAD: begin
            r_state   <= READ_SEND;
            r_miso_en <= 1'b1;
          end
          READ_SEND: begin
            if (w_hit) begin
              r_state   <= DONE;
              r_miso_en <= 1'b0;
            end
          end
          WRITE_RECV: begin
            if (w_hit) begin
              r_state <= WRITE_STORE;
              r_dm_we <= 1'b1;
            end
          end
          WRITE_STORE: r_state <= DONE;
          DONE:        r_state <= DONE;
          default:     r_state <= IDLE;
        endcase
      end
    end
  end

  assign srParallelLoad   = r_sr_load;
  assign addrLatchEnable  = r_addr_le;
  assign dmWriteEnable    = r_dm_we;
  assign misoBufferEnable = r_miso_en;
  assign busy             = r_busy;
  assign stateOut         = r_state;

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// Scoreboard bench for spi_transaction_ctrl: directed SPI transactions with per-cycle expectations.
module tb_spi_transaction_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclkPosEdge;
  logic       sclkNegEdge;
  logic       chipSelect;
  logic       rwBit;
  logic       srParallelLoad;
  logic       addrLatchEnable;
  logic       dmWriteEnable;
  logic       misoBufferEnable;
  logic       busy;
  logic [2:0] stateOut;

  spi_transaction_ctrl #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sclkPosEdge      (sclkPosEdge),
    .sclkNegEdge      (sclkNegEdge),
    .chipSelect       (chipSelect),
    .rwBit            (rwBit),
    .srParallelLoad   (srParallelLoad),
    .addrLatchEnable  (addrLatchEnable),
    .dmWriteEnable    (dmWriteEnable),
    .misoBufferEnable (misoBufferEnable),
    .busy             (busy),
    .stateOut         (stateOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_pulse = -100;
  bit   inject = 1'b0;

  // Packed observation: {stateOut, busy, addrLatchEnable, srParallelLoad, dmWriteEnable, misoBufferEnable}
  function automatic logic [7:0] V(input logic [2:0] st, input logic b, input logic a,
                                   input logic s, input logic d, input logic m);
    return {st, b, a, s, d, m};
  endfunction

  logic [7:0] obs;
  exp_t       e;

  always @(negedge clk) begin
    obs = {stateOut, busy, addrLatchEnable, srParallelLoad, dmWriteEnable, misoBufferEnable};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never sampled, required %b at cycle %0d", e.nm, e.v, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (cycle %0d)", e.nm, obs, e.v, cyc);
      end
    end else if (addrLatchEnable || srParallelLoad || dmWriteEnable) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_strobe: got %b required no strobe (cycle %0d)", obs, cyc);
    end
    if (sclkPosEdge && sclkNegEdge) begin
      n_tests++;
      n_fail++;
      $display("FAIL sclk_both_edges: got both pulses high, required at most one (cycle %0d)", cyc);
    end
    if (sclkPosEdge || sclkNegEdge) begin
      if (!inject && (cyc - last_pulse) < 4) begin
        n_tests++;
        n_fail++;
        $display("FAIL sclk_spacing: got %0d cycles, required >= 4 (cycle %0d)", cyc - last_pulse, cyc);
      end
      last_pulse = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation applies to the outputs after the inputs currently driven are sampled.
  task automatic expect_tick(input logic [7:0] v, input string nm);
    exp_t x;
    x.cyc = cyc + 1;
    x.v   = v;
    x.nm  = nm;
    exp_q.push_back(x);
    tick();
  endtask

  task automatic pulse(input bit pos);
    if (pos) sclkPosEdge = 1'b1;
    else     sclkNegEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic start_cs();
    chipSelect = 1'b0;
    expect_tick(V(3'd1, 1, 0, 0, 0, 0), "get_addr");
    tick();
  endtask

  task automatic end_cs(input string nm);
    chipSelect = 1'b1;
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), nm);
    tick();
  endtask

  task automatic addr_phase(input logic rw, input bit inj);
    rwBit = rw;
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1);
      pulse(1'b0);
    end
    sclkPosEdge = 1'b1;
    expect_tick(V(3'd2, 1, 1, 0, 0, 0), "addr_latch");
    if (inj) inject = 1'b1;
    else     sclkPosEdge = 1'b0;
    expect_tick(rw ? V(3'd3, 1, 0, 1, 0, 0) : V(3'd5, 1, 0, 0, 0, 0),
                rw ? "read_load" : "write_recv");
    sclkPosEdge = 1'b0;
    inject = 1'b0;
    if (rw) expect_tick(V(3'd4, 1, 0, 0, 0, 1), "read_send_start");
    else    tick();
    tick();
    if (inj) tick();
  endtask

  task automatic write_data();
    pulse(1'b0);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1);
      pulse(1'b0);
    end
    sclkPosEdge = 1'b1;
    expect_tick(V(3'd6, 1, 0, 0, 1, 0), "write_store");
    sclkPosEdge = 1'b0;
    expect_tick(V(3'd7, 1, 0, 0, 0, 0), "write_done");
    tick();
    tick();
    pulse(1'b0);
  endtask

  task automatic read_data();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) pulse(1'b1);
      sclkNegEdge = 1'b1;
      if (k == 7)      expect_tick(V(3'd4, 1, 0, 0, 0, 1), "read_send_hold");
      else if (k == 8) expect_tick(V(3'd7, 1, 0, 0, 0, 0), "read_done");
      else             tick();
      sclkNegEdge = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    chipSelect  = 1'b1;
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    rwBit       = 1'b0;
    tick();
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), "reset_state");
    reset = 1'b0;
    tick();

    // Write: address 0x2A with rw=0 (0x54), then data byte
    start_cs();
    addr_phase(1'b0, 1'b0);
    write_data();
    end_cs("write_end");

    // Read: address 0x2A with rw=1 (0x55)
    start_cs();
    addr_phase(1'b1, 1'b0);
    read_data();
    end_cs("read_end");

    // Abort after 5 address edges, then a clean write
    start_cs();
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1);
      pulse(1'b0);
    end
    chipSelect = 1'b1;
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), "abort_idle");
    tick();
    start_cs();
    addr_phase(1'b0, 1'b0);
    write_data();
    end_cs("write_after_abort");

    // Reset after 3 falling edges of READ_SEND, CS held low
    start_cs();
    addr_phase(1'b1, 1'b0);
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    reset = 1'b1;
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), "reset_mid_read");
    reset = 1'b0;
    expect_tick(V(3'd1, 1, 0, 0, 0, 0), "reset_reget_addr");
    tick();
    addr_phase(1'b0, 1'b0);
    write_data();
    end_cs("write_after_reset");

    // CS rises together with the 8th data rising edge
    start_cs();
    addr_phase(1'b0, 1'b0);
    pulse(1'b0);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1);
      pulse(1'b0);
    end
    sclkPosEdge = 1'b1;
    chipSelect  = 1'b1;
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), "cs_rise_on_last_edge");
    sclkPosEdge = 1'b0;
    expect_tick(V(3'd0, 0, 0, 0, 0, 0), "cs_rise_stays_idle");
    tick();
    tick();

    // Extra edge during GOT_ADDR, then DONE hold with 10 extra edges
    start_cs();
    addr_phase(1'b0, 1'b1);
    write_data();
    for (int i = 0; i < 5; i++) begin
      sclkPosEdge = 1'b1;
      expect_tick(V(3'd7, 1, 0, 0, 0, 0), "done_hold_pos");
      sclkPosEdge = 1'b0;
      tick();
      tick();
      tick();
      sclkNegEdge = 1'b1;
      expect_tick(V(3'd7, 1, 0, 0, 0, 0), "done_hold_neg");
      sclkNegEdge = 1'b0;
      tick();
      tick();
      tick();
    end
    end_cs("done_hold_end");

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
